// File: rtl/pcfx_yuv2rgb.sv
// PC-FX YUV to RGB video output stage: 3-stage BT.601 fixed-point pipeline with raw bypass.
// Optional macro PCFX_RGB_BLANK_EN forces RGB to black while the delayed blanks are active.
module pcfx_yuv2rgb #(
  parameter int KRV = 359,
  parameter int KGU = 88,
  parameter int KGV = 183,
  parameter int KBU = 454
) (
  input  logic       CLK,
  input  logic       RESn,
  input  logic       BYPASS,
  input  logic       VID_PCE,
  input  logic [7:0] VID_Y,
  input  logic [7:0] VID_U,
  input  logic [7:0] VID_V,
  input  logic       VID_HSn,
  input  logic       VID_VSn,
  input  logic       VID_HBL,
  input  logic       VID_VBL,
  output logic       CE_PIX,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       HBLANK,
  output logic       VBLANK
);

  localparam int unsigned CW    = 6;
  localparam int unsigned C_BYP = 5;
  localparam int unsigned C_PCE = 4;
  localparam int unsigned C_HS  = 3;
  localparam int unsigned C_VS  = 2;
  localparam int unsigned C_HBL = 1;
  localparam int unsigned C_VBL = 0;
  // Idle control word: blanks asserted, everything else low
  localparam logic [CW-1:0] CTL_IDLE = 6'b000011;

  localparam logic signed [17:0] K_RV  = signed'(18'(KRV));
  localparam logic signed [17:0] K_GU  = signed'(18'(KGU));
  localparam logic signed [17:0] K_GV  = signed'(18'(KGV));
  localparam logic signed [17:0] K_BU  = signed'(18'(KBU));
  localparam logic signed [17:0] RND   = 18'sd128;
  localparam logic signed [10:0] MAX8  = 11'sd255;

  // Stage 1: centre chroma, invert syncs, keep raw chroma for bypass
  logic [7:0]        y_s1, ur_s1, vr_s1;
  logic signed [8:0] u_s1, v_s1;
  logic [CW-1:0]     ctl_s1;

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      y_s1   <= '0;
      ur_s1  <= '0;
      vr_s1  <= '0;
      u_s1   <= '0;
      v_s1   <= '0;
      ctl_s1 <= CTL_IDLE;
    end else begin
      y_s1   <= VID_Y;
      ur_s1  <= VID_U;
      vr_s1  <= VID_V;
      u_s1   <= signed'({1'b0, VID_U}) - 9'sd128;
      v_s1   <= signed'({1'b0, VID_V}) - 9'sd128;
      ctl_s1 <= {BYPASS, VID_PCE, ~VID_HSn, ~VID_VSn, VID_HBL, VID_VBL};
    end
  end

  // Stage 2: chroma products, rounded and floor-shifted
  logic signed [17:0] u_x, v_x;
  logic signed [17:0] t_r_c, t_g_c, t_b_c;

  always_comb begin
    u_x   = 18'(u_s1);
    v_x   = 18'(v_s1);
    t_r_c = (K_RV * v_x + RND) >>> 8;
    t_g_c = (K_GU * u_x + K_GV * v_x + RND) >>> 8;
    t_b_c = (K_BU * u_x + RND) >>> 8;
  end

  logic [7:0]         y_s2, ur_s2, vr_s2;
  logic signed [17:0] t_r_s2, t_g_s2, t_b_s2;
  logic [CW-1:0]      ctl_s2;

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      y_s2   <= '0;
      ur_s2  <= '0;
      vr_s2  <= '0;
      t_r_s2 <= '0;
      t_g_s2 <= '0;
      t_b_s2 <= '0;
      ctl_s2 <= CTL_IDLE;
    end else begin
      y_s2   <= y_s1;
      ur_s2  <= ur_s1;
      vr_s2  <= vr_s1;
      t_r_s2 <= t_r_c;
      t_g_s2 <= t_g_c;
      t_b_s2 <= t_b_c;
      ctl_s2 <= ctl_s1;
    end
  end

  // Stage 3: luma sums in 11-bit signed, clamp, bypass / blank select
  function automatic logic [7:0] clamp8(input logic signed [10:0] s);
    if (s[10])
      return 8'h00;
    else if (s > MAX8)
      return 8'hFF;
    else
      return s[7:0];
  endfunction

  logic signed [10:0] y_x, sum_r, sum_g, sum_b;
  logic [7:0]         r_c, g_c, b_c;

  always_comb begin
    y_x   = signed'({3'b000, y_s2});
    sum_r = y_x + 11'(t_r_s2);
    sum_g = y_x - 11'(t_g_s2);
    sum_b = y_x + 11'(t_b_s2);
    r_c   = clamp8(sum_r);
    g_c   = clamp8(sum_g);
    b_c   = clamp8(sum_b);
    if (ctl_s2[C_BYP]) begin
      r_c = ur_s2;
      g_c = y_s2;
      b_c = vr_s2;
    end
`ifdef PCFX_RGB_BLANK_EN
    if (ctl_s2[C_HBL] || ctl_s2[C_VBL]) begin
      r_c = 8'h00;
      g_c = 8'h00;
      b_c = 8'h00;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      R      <= '0;
      G      <= '0;
      B      <= '0;
      CE_PIX <= 1'b0;
      HSYNC  <= 1'b0;
      VSYNC  <= 1'b0;
      HBLANK <= 1'b1;
      VBLANK <= 1'b1;
    end else begin
      R      <= r_c;
      G      <= g_c;
      B      <= b_c;
      CE_PIX <= ctl_s2[C_PCE];
      HSYNC  <= ctl_s2[C_HS];
      VSYNC  <= ctl_s2[C_VS];
      HBLANK <= ctl_s2[C_HBL];
      VBLANK <= ctl_s2[C_VBL];
    end
  end

endmodule
